zxvga_htiming: RTL and testbench

- Parametrised horizontal timing generator for the zxvga video path.
- Decodes machine_timing into a timing class. Each class has its own front porch and total line length.
- Runs a pixel-enabled horizontal counter and produces registered active, blank, sync and last-pixel flags for the VGA scan-out logic.
- Mode changes take effect only on line boundaries, so no line is ever malformed.

---
 rtl/zxvga_pkg.sv | 34 +++
 rtl/zxvga_hmode_decode.sv | 39 +++
 rtl/zxvga_htiming.sv | 166 ++++++++++++++++
 tb/tb_zxvga_htiming.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/zxvga_pkg.sv
// rtl/zxvga_pkg.sv - zxvga timing classes, machine_timing decode and default timing constants
package zxvga_pkg;

    typedef enum logic [1:0] {
        CLS_48K  = 2'd0,
        CLS_128K = 2'd1,
        CLS_PENT = 2'd2
    } zx_class_t;

    localparam int DEF_CW        = 11;
    localparam int DEF_H_ACTIVE  = 720;
    localparam int DEF_H_SYNC    = 64;
    localparam int DEF_FP_48K    = 48;
    localparam int DEF_FP_128K   = 64;
    localparam int DEF_FP_PENT   = 48;
    localparam int DEF_TOT_48K   = 896;
    localparam int DEF_TOT_128K  = 912;
    localparam int DEF_TOT_PENT  = 896;
    localparam int DEF_HSYNC_POL = 0;

    // bit 1 selects 128k over everything; bit 2 selects Pentagon; bit 0 is ignored
    function automatic zx_class_t zx_decode(input logic [2:0] mt);
        zx_class_t cls;
        if (mt[1]) begin
            cls = CLS_128K;
        end else if (mt[2]) begin
            cls = CLS_PENT;
        end else begin
            cls = CLS_48K;
        end
        return cls;
    endfunction

endpackage

// File: rtl/zxvga_hmode_decode.sv
// rtl/zxvga_hmode_decode.sv - maps a timing class to its front porch and total line length
module zxvga_hmode_decode
    import zxvga_pkg::*;
#(
    parameter int CW       = DEF_CW,
    parameter int FP_48K   = DEF_FP_48K,
    parameter int FP_128K  = DEF_FP_128K,
    parameter int FP_PENT  = DEF_FP_PENT,
    parameter int TOT_48K  = DEF_TOT_48K,
    parameter int TOT_128K = DEF_TOT_128K,
    parameter int TOT_PENT = DEF_TOT_PENT
)
(
    input  zx_class_t       i_class,
    output logic [CW-1:0]   o_fp,
    output logic [CW-1:0]   o_tot
);

    // table lookup; the unused encoding falls back to 48k timing
    always_comb begin
        o_fp  = CW'(FP_48K);
        o_tot = CW'(TOT_48K);
        case (i_class)
            CLS_128K: begin
                o_fp  = CW'(FP_128K);
                o_tot = CW'(TOT_128K);
            end
            CLS_PENT: begin
                o_fp  = CW'(FP_PENT);
                o_tot = CW'(TOT_PENT);
            end
            default: begin
                o_fp  = CW'(FP_48K);
                o_tot = CW'(TOT_48K);
            end
        endcase
    end

endmodule

// File: rtl/zxvga_htiming.sv
// rtl/zxvga_htiming.sv - horizontal timing generator; optional ZXVGA_FP_OVERRIDE_EN adds a front-porch override
module zxvga_htiming
    import zxvga_pkg::*;
#(
    parameter int CW        = DEF_CW,
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int FP_48K    = DEF_FP_48K,
    parameter int FP_128K   = DEF_FP_128K,
    parameter int FP_PENT   = DEF_FP_PENT,
    parameter int TOT_48K   = DEF_TOT_48K,
    parameter int TOT_128K  = DEF_TOT_128K,
    parameter int TOT_PENT  = DEF_TOT_PENT,
    parameter int HSYNC_POL = DEF_HSYNC_POL
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic            ce,
    input  logic [2:0]      machine_timing,
`ifdef ZXVGA_FP_OVERRIDE_EN
    input  logic [CW-1:0]   fp_override,
    input  logic            fp_override_valid,
    output logic            fp_override_err,
`endif
    output logic [CW-1:0]   hc,
    output logic            hactive,
    output logic            hblank,
    output logic            hsync,
    output logic            hlast,
    output logic [1:0]      tclass
);

    // two guard bits keep H_ACTIVE+fp+H_SYNC from wrapping during comparisons
    localparam int             XW     = CW + 2;
    localparam logic [XW-1:0]  L_ACT  = XW'(H_ACTIVE);
    localparam logic [XW-1:0]  L_SYNC = XW'(H_SYNC);
    localparam logic           L_POL  = (HSYNC_POL != 0);
    localparam longint         L_MAX  = longint'(1) << CW;

    if (!((H_ACTIVE + FP_48K + H_SYNC < TOT_48K) && (longint'(TOT_48K) <= L_MAX))) begin : g_bad_48k
        $error("zxvga_htiming: 48k timing does not fit the line or the counter");
    end
    if (!((H_ACTIVE + FP_128K + H_SYNC < TOT_128K) && (longint'(TOT_128K) <= L_MAX))) begin : g_bad_128k
        $error("zxvga_htiming: 128k timing does not fit the line or the counter");
    end
    if (!((H_ACTIVE + FP_PENT + H_SYNC < TOT_PENT) && (longint'(TOT_PENT) <= L_MAX))) begin : g_bad_pent
        $error("zxvga_htiming: Pentagon timing does not fit the line or the counter");
    end

    zx_class_t      r_class;
    logic [CW-1:0]  r_hc;
    logic [CW-1:0]  r_fp;
    logic [CW-1:0]  r_tot;
    logic           r_hactive;
    logic           r_hblank;
    logic           r_hsync;
    logic           r_hlast;

    zx_class_t      w_cls_in;
    zx_class_t      w_cls_nx;
    logic [CW-1:0]  w_tab_fp;
    logic [CW-1:0]  w_tab_tot;
    logic [CW-1:0]  w_new_fp;
    logic [CW-1:0]  w_fp_nx;
    logic [CW-1:0]  w_tot_nx;
    logic [CW-1:0]  w_hc_nx;
    logic           w_last;
    logic           w_reload;
    logic [XW-1:0]  w_hc_x;
    logic [XW-1:0]  w_ss;
    logic [XW-1:0]  w_se;
    logic           w_sync_on;
    logic           w_act_nx;
    logic           w_hsync_nx;
    logic           w_last_nx;

    assign w_cls_in = zx_decode(machine_timing);

    zxvga_hmode_decode #(
        .CW       (CW),
        .FP_48K   (FP_48K),
        .FP_128K  (FP_128K),
        .FP_PENT  (FP_PENT),
        .TOT_48K  (TOT_48K),
        .TOT_128K (TOT_128K),
        .TOT_PENT (TOT_PENT)
    ) u_hmode_decode (
        .i_class (w_cls_in),
        .o_fp    (w_tab_fp),
        .o_tot   (w_tab_tot)
    );

    // the class (and its fp/tot) is reloaded only at reset or on the enabled wrap cycle
    assign w_last   = (r_hc == (r_tot - CW'(1)));
    assign w_reload = reset | (ce & w_last);

`ifdef ZXVGA_FP_OVERRIDE_EN
    logic w_ov_ok;
    logic w_ov_err;
    logic r_ov_err;

    assign w_ov_ok  = ((L_ACT + {2'b00, fp_override} + L_SYNC) < {2'b00, w_tab_tot});
    assign w_ov_err = ~reset & fp_override_valid & ~w_ov_ok;
    assign w_new_fp = (~reset & fp_override_valid & w_ov_ok) ? fp_override : w_tab_fp;

    // sticky override error, raised on a wrap that rejects the requested porch
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ov_err <= 1'b0;
        end else if (ce & w_last & w_ov_err) begin
            r_ov_err <= 1'b1;
        end
    end

    assign fp_override_err = r_ov_err;
`else
    assign w_new_fp = w_tab_fp;
`endif

    // next counter value and the timing that applies to it
    always_comb begin
        w_hc_nx  = r_hc;
        w_cls_nx = w_reload ? w_cls_in  : r_class;
        w_fp_nx  = w_reload ? w_new_fp  : r_fp;
        w_tot_nx = w_reload ? w_tab_tot : r_tot;
        if (reset) begin
            w_hc_nx = '0;
        end else if (ce) begin
            w_hc_nx = w_last ? '0 : r_hc + CW'(1);
        end
    end

    // flags are derived from the next count so they register in step with hc
    always_comb begin
        w_hc_x     = {2'b00, w_hc_nx};
        w_ss       = L_ACT + {2'b00, w_fp_nx};
        w_se       = w_ss + L_SYNC;
        w_act_nx   = (w_hc_x < L_ACT);
        w_sync_on  = (w_hc_x >= w_ss) && (w_hc_x < w_se);
        w_hsync_nx = w_sync_on ? L_POL : ~L_POL;
        w_last_nx  = (w_hc_nx == (w_tot_nx - CW'(1)));
    end

    // state advances on ce; reset overrides ce
    always_ff @(posedge clk) begin
        if (reset | ce) begin
            r_hc      <= w_hc_nx;
            r_class   <= w_cls_nx;
            r_fp      <= w_fp_nx;
            r_tot     <= w_tot_nx;
            r_hactive <= w_act_nx;
            r_hblank  <= ~w_act_nx;
            r_hsync   <= w_hsync_nx;
            r_hlast   <= w_last_nx;
        end
    end

    assign hc      = r_hc;
    assign hactive = r_hactive;
    assign hblank  = r_hblank;
    assign hsync   = r_hsync;
    assign hlast   = r_hlast;
    assign tclass  = r_class;

endmodule

// File: tb/tb_zxvga_htiming.sv
// tb/tb_zxvga_htiming.sv - directed bench for zxvga_htiming
module tb_zxvga_htiming;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic [2:0]  machine_timing;
    logic [10:0] hc;
    logic        hactive;
    logic        hblank;
    logic        hsync;
    logic        hlast;
    logic [1:0]  tclass;
`ifdef ZXVGA_FP_OVERRIDE_EN
    logic [10:0] fp_override;
    logic        fp_override_valid;
    logic        fp_override_err;
`endif

    int checks   = 0;
    int failures = 0;
    int exp_hc   = 0;
    int n_bad, first_bad, n_last, n_sync;

    always #5 clk = ~clk;

    zxvga_htiming dut (
        .clk               (clk),
        .reset             (reset),
        .ce                (ce),
        .machine_timing    (machine_timing),
`ifdef ZXVGA_FP_OVERRIDE_EN
        .fp_override       (fp_override),
        .fp_override_valid (fp_override_valid),
        .fp_override_err   (fp_override_err),
`endif
        .hc                (hc),
        .hactive           (hactive),
        .hblank            (hblank),
        .hsync             (hsync),
        .hlast             (hlast),
        .tclass            (tclass)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // drives n pixel steps (each followed by gap ce=0 clocks) and tallies
    // cycles where the outputs disagree with the expected line model
    task automatic run_cycles(input int n, input int tot, input int ss, input int cls,
                              input int ncls, input int gap);
        int  e_cls;
        bit  e_act, e_sync, e_last, wrapped;
        n_bad = 0; first_bad = -1; n_last = 0; n_sync = 0; wrapped = 0;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g <= gap; g++) begin
                ce = (g == 0);
                step();
                if (g == 0) begin
                    if (exp_hc == tot - 1) begin
                        exp_hc  = 0;
                        wrapped = 1;
                    end else begin
                        exp_hc++;
                    end
                end
                e_cls  = wrapped ? ncls : cls;
                e_act  = (exp_hc < 720);
                e_sync = (exp_hc >= ss && exp_hc < ss + 64) ? 1'b0 : 1'b1;
                e_last = (exp_hc == tot - 1);
                if (hc !== exp_hc[10:0] || hactive !== e_act || hblank !== !e_act ||
                    hsync !== e_sync || hlast !== e_last || tclass !== e_cls[1:0]) begin
                    if (n_bad == 0) first_bad = exp_hc;
                    n_bad++;
                end
                if (hlast === 1'b1) n_last++;
                if (hsync === 1'b0) n_sync++;
            end
        end
        ce = 1'b1;
    endtask

    task automatic test_reset;
        machine_timing = 3'b000;
        ce = 1'b1;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        exp_hc = 0;
        checks++; if (hc !== 11'd0) begin failures++; $display("FAIL reset_hc got=%0d exp=0", hc); end
        checks++; if (hactive !== 1'b1) begin failures++; $display("FAIL reset_hactive got=%b exp=1", hactive); end
        checks++; if (hblank !== 1'b0) begin failures++; $display("FAIL reset_hblank got=%b exp=0", hblank); end
        checks++; if (hsync !== 1'b1) begin failures++; $display("FAIL reset_hsync got=%b exp=1", hsync); end
        checks++; if (hlast !== 1'b0) begin failures++; $display("FAIL reset_hlast got=%b exp=0", hlast); end
        checks++; if (tclass !== 2'd0) begin failures++; $display("FAIL reset_tclass got=%0d exp=0", tclass); end
    endtask

    task automatic test_48k_line;
        run_cycles(896, 896, 768, 0, 0, 0);
        checks++; if (n_bad !== 0) begin failures++; $display("FAIL line48k_flags bad=%0d first_hc=%0d exp_bad=0", n_bad, first_bad); end
        checks++; if (n_sync !== 64) begin failures++; $display("FAIL line48k_sync_len got=%0d exp=64", n_sync); end
        checks++; if (n_last !== 1) begin failures++; $display("FAIL line48k_hlast_len got=%0d exp=1", n_last); end
        checks++; if (hc !== 11'd0) begin failures++; $display("FAIL line48k_wrap got=%0d exp=0", hc); end
    endtask

    task automatic test_midline_switch;
        run_cycles(300, 896, 768, 0, 0, 0);
        machine_timing = 3'b010;
        run_cycles(596, 896, 768, 0, 1, 0);
        checks++; if (n_bad !== 0) begin failures++; $display("FAIL switch_flags bad=%0d first_hc=%0d exp_bad=0", n_bad, first_bad); end
        checks++; if (n_sync !== 64) begin failures++; $display("FAIL switch_sync_len got=%0d exp=64", n_sync); end
        checks++; if (tclass !== 2'd1) begin failures++; $display("FAIL switch_tclass got=%0d exp=1", tclass); end
    endtask

    task automatic test_128k_line;
        run_cycles(912, 912, 784, 1, 1, 0);
        checks++; if (n_bad !== 0) begin failures++; $display("FAIL line128k_flags bad=%0d first_hc=%0d exp_bad=0", n_bad, first_bad); end
        checks++; if (n_sync !== 64) begin failures++; $display("FAIL line128k_sync_len got=%0d exp=64", n_sync); end
        checks++; if (n_last !== 1) begin failures++; $display("FAIL line128k_hlast_len got=%0d exp=1", n_last); end
    endtask

    task automatic test_ce_gated;
        run_cycles(905, 912, 784, 1, 1, 0);
        run_cycles(10, 912, 784, 1, 1, 3);
        checks++; if (n_bad !== 0) begin failures++; $display("FAIL gated_flags bad=%0d first_hc=%0d exp_bad=0", n_bad, first_bad); end
        checks++; if (n_last !== 4) begin failures++; $display("FAIL gated_hlast_len got=%0d exp=4", n_last); end
        checks++; if (hc !== 11'd3) begin failures++; $display("FAIL gated_hc got=%0d exp=3", hc); end
    endtask

    task automatic test_reset_midline;
        run_cycles(497, 912, 784, 1, 1, 0);
        checks++; if (hc !== 11'd500) begin failures++; $display("FAIL midreset_pre_hc got=%0d exp=500", hc); end
        reset = 1'b1;
        ce = 1'b0;
        machine_timing = 3'b000;
        step();
        reset = 1'b0;
        exp_hc = 0;
        checks++; if (hc !== 11'd0) begin failures++; $display("FAIL midreset_hc got=%0d exp=0", hc); end
        checks++; if (hactive !== 1'b1) begin failures++; $display("FAIL midreset_hactive got=%b exp=1", hactive); end
        checks++; if (hsync !== 1'b1) begin failures++; $display("FAIL midreset_hsync got=%b exp=1", hsync); end
        checks++; if (hlast !== 1'b0) begin failures++; $display("FAIL midreset_hlast got=%b exp=0", hlast); end
        checks++; if (tclass !== 2'd0) begin failures++; $display("FAIL midreset_tclass got=%0d exp=0", tclass); end
    endtask

    task automatic test_back_to_back;
        machine_timing = 3'b100;
        run_cycles(896, 896, 768, 0, 2, 0);
        checks++; if (tclass !== 2'd2) begin failures++; $display("FAIL b2b_tclass got=%0d exp=2", tclass); end
        machine_timing = 3'b101;
        run_cycles(896, 896, 768, 2, 2, 0);
        checks++; if (n_bad !== 0) begin failures++; $display("FAIL b2b_pent_flags bad=%0d first_hc=%0d exp_bad=0", n_bad, first_bad); end
        checks++; if (n_sync !== 64) begin failures++; $display("FAIL b2b_pent_sync_len got=%0d exp=64", n_sync); end
    endtask

`ifdef ZXVGA_FP_OVERRIDE_EN
    task automatic test_fp_override;
        fp_override = 11'd100;
        fp_override_valid = 1'b1;
        machine_timing = 3'b000;
        run_cycles(896, 896, 768, 2, 0, 0);
        checks++; if (fp_override_err !== 1'b0) begin failures++; $display("FAIL ov_err_clear got=%b exp=0", fp_override_err); end
        fp_override = 11'd200;
        run_cycles(896, 896, 820, 0, 0, 0);
        checks++; if (n_bad !== 0) begin failures++; $display("FAIL ov100_flags bad=%0d first_hc=%0d exp_bad=0", n_bad, first_bad); end
        checks++; if (n_sync !== 64) begin failures++; $display("FAIL ov100_sync_len got=%0d exp=64", n_sync); end
        checks++; if (fp_override_err !== 1'b1) begin failures++; $display("FAIL ov200_err got=%b exp=1", fp_override_err); end
        run_cycles(896, 896, 768, 0, 0, 0);
        checks++; if (n_bad !== 0) begin failures++; $display("FAIL ov200_table_flags bad=%0d first_hc=%0d exp_bad=0", n_bad, first_bad); end
        checks++; if (fp_override_err !== 1'b1) begin failures++; $display("FAIL ov_err_sticky got=%b exp=1", fp_override_err); end
        fp_override_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_hc = 0;
        checks++; if (fp_override_err !== 1'b0) begin failures++; $display("FAIL ov_err_reset got=%b exp=0", fp_override_err); end
    endtask
`endif

    initial begin
        reset = 1'b1;
        ce = 1'b0;
        machine_timing = 3'b000;
`ifdef ZXVGA_FP_OVERRIDE_EN
        fp_override = '0;
        fp_override_valid = 1'b0;
`endif
        test_reset();
        test_48k_line();
        test_midline_switch();
        test_128k_line();
        test_ce_gated();
        test_reset_midline();
        test_back_to_back();
`ifdef ZXVGA_FP_OVERRIDE_EN
        test_fp_override();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
